spi_regfile_periph: RTL
=======================

Name: spi_regfile_periph

Overview:
- Parametrised SPI Mode-0 peripheral exposing a bank of NUM_REGS control registers to an off-chip controller.
- Oversamples SCLK, nCS and COPI on the system clock.
- Supports both write and read frames; reads return register data on CIPO.
- Write commit is strictly once per complete frame; short frames are aborted, and status strobes go to the rest of the design.

Parameters:
- ADDR_W, 7, address field width in bits.
- DATA_W, 8, register data width in bits.
- NUM_REGS, 5, implemented registers at addresses 0..NUM_REGS-1 (1 <= NUM_REGS <= 2**ADDR_W).
- SYNC_STAGES, 2, flip-flop depth of each input synchroniser (>= 2).

Ports:
- clk  in  1  system clock; must be >= 8x SCLK frequency.
- rst_n  in  1  reset, asynchronous, active-low.
- sclk  in  1  SPI clock, asynchronous.
- ncs  in  1  SPI chip select, active-low, asynchronous.
- copi  in  1  controller-out data, asynchronous.
- cipo  out  1  peripheral-out data.
- cipo_oe  out  1  CIPO output enable (high while the synchronised nCS is low).
- regs_flat  out  NUM_REGS*DATA_W  register contents; reg i occupies bits [i*DATA_W +: DATA_W].
- wr_stb  out  1  one-cycle pulse when a register is written.
- wr_addr  out  ADDR_W  address of the last commit; valid with wr_stb.
- frame_err  out  1  one-cycle pulse on an aborted or invalid-address frame.

Behaviour:
- Frame format, MSB first: bit 0 = R/W (1 = write), then ADDR_W address bits, then DATA_W data bits. FRAME_W = 1+ADDR_W+DATA_W (16 by default).
- Synchronisers: each input passes through SYNC_STAGES flops. Edge detection compares the last two stages: SCLK rise, SCLK fall, nCS fall, nCS rise.
- States: IDLE, ADDR, DATA, DONE.
  - IDLE -> ADDR on nCS fall: bit counter := 0, shift register := 0.
  - ADDR: each SCLK rise while nCS is low shifts in one bit. After bit index ADDR_W is captured (counter == 1+ADDR_W) -> DATA.
  - DATA: shifts DATA_W more bits. When counter reaches FRAME_W -> DONE.
  - DONE: further SCLK edges are ignored and the counter saturates at FRAME_W.
  - Any state -> IDLE on nCS rise.
- Write commit: occurs in the clk cycle after entering DONE, exactly once per frame.
  - If R/W = 1 and addr < NUM_REGS: register := data and wr_stb = 1.
  - If addr >= NUM_REGS: no register changes and frame_err = 1.
  - Read frames never modify registers and never pulse wr_stb.
- Read path, when R/W = 0:
  - On entering DATA, the tx shift register loads reg[addr], or 0 if addr >= NUM_REGS.
  - cipo is updated on each SCLK fall during DATA, MSB first. The first data bit is presented at the SCLK fall following the last address bit.
  - cipo = 0 outside read DATA.
  - An invalid-address read also pulses frame_err at DONE entry.
- Abort: an nCS rise in ADDR or DATA pulses frame_err for one cycle and leaves registers and wr_stb untouched.
- Simultaneous events:
  - nCS fall in the same cycle as an SCLK rise: nCS wins and the counter resets.
  - nCS rise in the same cycle as the final SCLK rise: the frame is treated as aborted.
- Reset values: all registers 0, regs_flat = 0, cipo = 0, cipo_oe = 0, wr_stb = 0, wr_addr = 0, frame_err = 0, state IDLE, synchronisers 0.
- Reset mid-frame: immediate return to IDLE with all reset values. No commit occurs; the partial frame is lost.

Decomposition:
- Shared package spi_pkg holds:
  - state enum (IDLE/ADDR/DATA/DONE);
  - RW_WRITE = 1'b1;
  - FRAME_W derivation function.
- One sub-module, spi_sync_edge: a SYNC_STAGES-deep synchroniser plus rise/fall pulse outputs, instantiated for sclk and ncs. copi uses the synchroniser only.

Test Plan:
- Write 0x80_A5 (write, addr 0, data 0xA5) -> reg0 = 0xA5; wr_stb pulses once with wr_addr = 0; no other register changes.
- Write 0x84_3C (addr 4), then read 0x04_xx -> cipo shifts 0x3C MSB-first on the 8 data-phase SCLK falls; reg4 stays 0x3C; no wr_stb.
- Write 0x85_FF (addr 5, NUM_REGS = 5) -> frame_err pulses; regs_flat unchanged; no wr_stb.
- Raise nCS after 10 SCLK rises of write 0x81_55 -> frame_err pulses; reg1 stays 0.
- Write 0x82_11 with 20 SCLK pulses -> reg2 = 0x11; wr_stb pulses exactly once; extra clocks ignored.
- Assert rst_n low mid-frame after reg3 = 0x77, then send a fresh write 0x83_22 -> all registers 0 after reset, then reg3 = 0x22.

Source files
------------

// File: rtl/spi_pkg.sv
// Shared types and helpers for the SPI register-file peripheral.
// Holds the frame-FSM state encoding and the frame-length derivation.
package spi_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_ADDR = 2'd1,
        ST_DATA = 2'd2,
        ST_DONE = 2'd3
    } spi_state_e;

    localparam logic RW_WRITE = 1'b1;

    function automatic int frame_w(input int addr_w, input int data_w);
        return 1 + addr_w + data_w;
    endfunction

endpackage

// File: rtl/spi_sync_edge.sv
// SYNC_STAGES-deep input synchroniser with rise/fall pulses taken from
// the last two stages; level_o is the fully synchronised value.
module spi_sync_edge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic level_o,
    output logic rise_o,
    output logic fall_o
);

    logic [SYNC_STAGES-1:0] sync_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[SYNC_STAGES-2:0], d_i};
        end
    end

    assign level_o = sync_q[SYNC_STAGES-1];
    assign rise_o  = sync_q[SYNC_STAGES-2] & ~sync_q[SYNC_STAGES-1];
    assign fall_o  = ~sync_q[SYNC_STAGES-2] & sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/spi_regfile_periph.sv
// SPI Mode-0 peripheral exposing NUM_REGS registers; frame = R/W, address,
// data (MSB first), committed once per complete frame, aborted on early nCS rise.
module spi_regfile_periph
    import spi_pkg::*;
#(
    parameter int ADDR_W      = 7,
    parameter int DATA_W      = 8,
    parameter int NUM_REGS    = 5,
    parameter int SYNC_STAGES = 2
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic                       sclk,
    input  logic                       ncs,
    input  logic                       copi,
    output logic                       cipo,
    output logic                       cipo_oe,
    output logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic                       wr_stb,
    output logic [ADDR_W-1:0]          wr_addr,
    output logic                       frame_err,
    output spi_state_e                 dbg_state_o
);

    localparam int FRAME_W = frame_w(ADDR_W, DATA_W);
    localparam int CNT_W   = $clog2(FRAME_W + 1);
    localparam logic [CNT_W-1:0]  CNT_ADDR_END  = CNT_W'(1 + ADDR_W);
    localparam logic [CNT_W-1:0]  CNT_FRAME_END = CNT_W'(FRAME_W);
    localparam logic [ADDR_W:0]   NUM_REGS_W    = (ADDR_W + 1)'(NUM_REGS);

    logic sclk_rise, sclk_fall, sclk_unused_lvl;
    logic ncs_rise, ncs_fall, ncs_unused_lvl;
    logic copi_lvl, copi_unused_rise, copi_unused_fall;

    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_sclk (
        .clk(clk), .rst_n(rst_n), .d_i(sclk),
        .level_o(sclk_unused_lvl), .rise_o(sclk_rise), .fall_o(sclk_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_ncs (
        .clk(clk), .rst_n(rst_n), .d_i(ncs),
        .level_o(ncs_unused_lvl), .rise_o(ncs_rise), .fall_o(ncs_fall)
    );
    spi_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync_copi (
        .clk(clk), .rst_n(rst_n), .d_i(copi),
        .level_o(copi_lvl), .rise_o(copi_unused_rise), .fall_o(copi_unused_fall)
    );

    spi_state_e           state_q, state_d;
    logic [CNT_W-1:0]     cnt_q, cnt_d, cnt_inc;
    logic [FRAME_W-1:0]   shift_q, shift_d;
    logic [DATA_W-1:0]    tx_q, tx_d;
    logic [ADDR_W-1:0]    addr_q, addr_d, wr_addr_q, wr_addr_d;
    logic                 rw_q, rw_d, cipo_q, cipo_d;
    logic                 done_first_q, done_first_d;
    logic                 wr_stb_q, wr_stb_d, frame_err_q, frame_err_d;
    logic                 reg_wr_en, shift_en;
    logic [DATA_W-1:0]    regs_q [NUM_REGS];

    assign cnt_inc  = cnt_q + CNT_W'(1);
    assign shift_en = sclk_rise && !ncs_rise && (state_q == ST_ADDR || state_q == ST_DATA);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // nCS rise dominates every other event, so a rise on the final SCLK edge aborts.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE: if (ncs_fall) state_d = ST_ADDR;
            ST_ADDR: begin
                if (ncs_rise)                                   state_d = ST_IDLE;
                else if (sclk_rise && cnt_inc == CNT_ADDR_END)  state_d = ST_DATA;
            end
            ST_DATA: begin
                if (ncs_rise)                                   state_d = ST_IDLE;
                else if (sclk_rise && cnt_inc == CNT_FRAME_END) state_d = ST_DONE;
            end
            ST_DONE: if (ncs_rise) state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        cnt_d        = cnt_q;
        shift_d      = shift_q;
        tx_d         = tx_q;
        cipo_d       = cipo_q;
        rw_d         = rw_q;
        addr_d       = addr_q;
        wr_addr_d    = wr_addr_q;
        wr_stb_d     = 1'b0;
        frame_err_d  = 1'b0;
        reg_wr_en    = 1'b0;
        done_first_d = (state_q == ST_DATA) && (state_d == ST_DONE);
        if (state_q == ST_IDLE && ncs_fall) begin
            cnt_d   = '0;
            shift_d = '0;
            cipo_d  = 1'b0;
        end
        if (shift_en) begin
            shift_d = {shift_q[FRAME_W-2:0], copi_lvl};
            cnt_d   = cnt_inc;
        end
        if (state_q == ST_ADDR && state_d == ST_DATA) begin
            rw_d   = shift_d[ADDR_W];
            addr_d = shift_d[ADDR_W-1:0];
            tx_d   = '0;
            for (int i = 0; i < NUM_REGS; i++) begin
                if (addr_d == ADDR_W'(i)) tx_d = regs_q[i];
            end
        end
        if (state_q == ST_DATA && sclk_fall && rw_q != RW_WRITE) begin
            cipo_d = tx_q[DATA_W-1];
            tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
        if ((state_q == ST_ADDR || state_q == ST_DATA) && ncs_rise) frame_err_d = 1'b1;
        if (done_first_q) begin
            if ({1'b0, addr_q} >= NUM_REGS_W) begin
                frame_err_d = 1'b1;
            end else if (rw_q == RW_WRITE) begin
                reg_wr_en = 1'b1;
                wr_stb_d  = 1'b1;
                wr_addr_d = addr_q;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q        <= '0;
            shift_q      <= '0;
            tx_q         <= '0;
            cipo_q       <= 1'b0;
            rw_q         <= 1'b0;
            addr_q       <= '0;
            wr_addr_q    <= '0;
            wr_stb_q     <= 1'b0;
            frame_err_q  <= 1'b0;
            done_first_q <= 1'b0;
        end else begin
            cnt_q        <= cnt_d;
            shift_q      <= shift_d;
            tx_q         <= tx_d;
            cipo_q       <= cipo_d;
            rw_q         <= rw_d;
            addr_q       <= addr_d;
            wr_addr_q    <= wr_addr_d;
            wr_stb_q     <= wr_stb_d;
            frame_err_q  <= frame_err_d;
            done_first_q <= done_first_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NUM_REGS; i++) regs_q[i] <= '0;
        end else begin
            for (int i = 0; i < NUM_REGS; i++) begin
                if (reg_wr_en && addr_q == ADDR_W'(i)) regs_q[i] <= shift_q[DATA_W-1:0];
            end
        end
    end

    for (genvar g = 0; g < NUM_REGS; g++) begin : g_flat
        assign regs_flat[g*DATA_W +: DATA_W] = regs_q[g];
    end

    // A stale bit in cipo_q must never leak outside the read data phase.
    assign cipo        = cipo_q & (state_q == ST_DATA) & (rw_q != RW_WRITE);
    assign cipo_oe     = (state_q != ST_IDLE);
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign frame_err   = frame_err_q;
    assign dbg_state_o = state_q;

endmodule
